// File: rtl/load_store_unit_if.sv
// Request, data-memory bus and write-back signals of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned XLEN = 32
);
    // Request from execute
    logic            req_valid;
    logic            req_ready;
    logic            is_store;
    logic [2:0]      mem_op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd_in;

    // Data-memory bus
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    // Write-back / exception
    logic            wb_valid;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            exc_valid;
    logic [1:0]      exc_cause;

    // Load/store unit side
    modport slave (
        input  req_valid, is_store, mem_op, addr, store_data, rd_in,
        input  dmem_ack, dmem_rdata,
        output req_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_cause
    );

    // Pipeline / memory side
    modport master (
        output req_valid, is_store, mem_op, addr, store_data, rd_in,
        output dmem_ack, dmem_rdata,
        input  req_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_cause
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/ack data-memory transaction per request,
// with alignment checks, byte enables, load extension and a bus timeout.
module load_store_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    load_store_unit_if.slave  bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MIS_LD  = 2'd0;
    localparam logic [1:0] CAUSE_MIS_ST  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             store_q, store_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [4:0]       rd_q, rd_d;

    logic             req_ready_q, req_ready_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]  dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]  dmem_wdata_q, dmem_wdata_d;
    logic [3:0]       dmem_be_q, dmem_be_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic             exc_valid_q, exc_valid_d;
    logic [1:0]       exc_cause_q, exc_cause_d;

    logic             illegal_op;
    logic             misaligned;
    logic [XLEN-1:0]  st_wdata;
    logic [3:0]       st_be;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  ld_result;

    // Decode the incoming request: legality, alignment and store lane formatting
    always_comb begin
        illegal_op = 1'b0;
        misaligned = 1'b0;
        st_wdata   = '0;
        st_be      = 4'b1111;
        if (bus.is_store) begin
            illegal_op = (bus.mem_op != 3'b000) && (bus.mem_op != 3'b001) && (bus.mem_op != 3'b010);
        end else begin
            illegal_op = (bus.mem_op == 3'b011) || (bus.mem_op == 3'b110) || (bus.mem_op == 3'b111);
        end
        case (bus.mem_op[1:0])
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (bus.is_store) begin
            case (bus.mem_op[1:0])
                2'b00: begin
                    st_wdata = {4{bus.store_data[7:0]}};
                    st_be    = 4'b0001 << bus.addr[1:0];
                end
                2'b01: begin
                    st_wdata = {2{bus.store_data[15:0]}};
                    st_be    = 4'b0011 << {bus.addr[1], 1'b0};
                end
                default: begin
                    st_wdata = bus.store_data;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Select and extend the load result from the returned word
    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo_q)
            2'd0:    ld_byte = bus.dmem_rdata[7:0];
            2'd1:    ld_byte = bus.dmem_rdata[15:8];
            2'd2:    ld_byte = bus.dmem_rdata[23:16];
            default: ld_byte = bus.dmem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (op_q)
            3'b000:  ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_result = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_result = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_result = bus.dmem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        op_d         = op_q;
        addr_lo_d    = addr_lo_q;
        rd_d         = rd_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = '0;
        wb_data_d    = '0;
        exc_valid_d  = 1'b0;
        exc_cause_d  = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d   = bus.is_store;
                    op_d      = bus.mem_op;
                    addr_lo_d = bus.addr[1:0];
                    rd_d      = bus.rd_in;
                    if (illegal_op || misaligned) begin
                        // Rejected without touching the bus
                        state_d     = RESP;
                        wb_valid_d  = 1'b1;
                        wb_rd_d     = bus.rd_in;
                        exc_valid_d = 1'b1;
                        exc_cause_d = illegal_op    ? CAUSE_ILLEGAL :
                                      bus.is_store  ? CAUSE_MIS_ST  : CAUSE_MIS_LD;
                    end else begin
                        state_d      = BUSY;
                        cnt_d        = '0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = bus.is_store;
                        dmem_addr_d  = {bus.addr[XLEN-1:2], 2'b00};
                        dmem_wdata_d = st_wdata;
                        dmem_be_d    = st_be;
                    end
                end
            end
            BUSY: begin
                if (bus.dmem_ack || (cnt_q == CNT_LAST)) begin
                    // Ack wins over a simultaneous timeout
                    state_d      = RESP;
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    dmem_addr_d  = '0;
                    dmem_wdata_d = '0;
                    dmem_be_d    = '0;
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = rd_q;
                    if (!bus.dmem_ack) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = CAUSE_TIMEOUT;
                    end else if (!store_q) begin
                        wb_we_d   = (rd_q != 5'd0);
                        wb_data_d = ld_result;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            op_q         <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
            req_ready_q  <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            op_q         <= op_d;
            addr_lo_q    <= addr_lo_d;
            rd_q         <= rd_d;
            req_ready_q  <= req_ready_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            exc_valid_q  <= exc_valid_d;
            exc_cause_q  <= exc_cause_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_we      = wb_we_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.exc_valid  = exc_valid_q;
    assign bus.exc_cause  = exc_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expectations, a bus
// responder and a write-back monitor check them independently.
module tb_load_store_unit;
    localparam int unsigned T = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [1:0]  cause;
        int          lat;
    } wb_t;

    typedef struct {
        int          ws;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          req_cycles;
    } bt_t;

    wb_t exp_q[$];
    bt_t bus_q[$];
    int  acc_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_wb(input logic we, input logic [4:0] rd, input logic [31:0] data,
                          input logic exc, input logic [1:0] cause, input int lat);
        wb_t e;
        e.we = we; e.rd = rd; e.data = data; e.exc = exc; e.cause = cause; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic exp_bus(input int ws, input logic [31:0] rdata, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int req_cycles);
        bt_t b;
        b.ws = ws; b.rdata = rdata; b.we = we; b.addr = addr; b.wdata = wdata;
        b.be = be; b.req_cycles = req_cycles;
        bus_q.push_back(b);
    endtask

    // Present a request at a falling edge and return at the falling edge after acceptance
    task automatic send(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd);
        int k;
        k = 0;
        bus.req_valid  = 1'b1;
        bus.is_store   = st;
        bus.mem_op     = op;
        bus.addr       = a;
        bus.store_data = sd;
        bus.rd_in      = rd;
        while (!bus.req_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("accept_wait", 64'(k < 300), 64'(1));
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.dmem_req) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(k < 200), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    // Record acceptance edges for latency measurement
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset_n && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    end

    // Write-back monitor
    always @(negedge clk) begin
        wb_t e;
        int  a;
        if (!reset_n) begin
            acc_q.delete();
        end else if (bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb_valid: got rd=%0d data=0x%0h required none", bus.wb_rd, bus.wb_data);
            end else begin
                e = exp_q.pop_front();
                check("wb_fields", 64'({bus.wb_we, bus.wb_rd, bus.wb_data, bus.exc_valid, bus.exc_cause}),
                      64'({e.we, e.rd, e.data, e.exc, e.cause}));
                if (acc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_latency: got wb_valid without accept, required accept first");
                end else begin
                    a = acc_q.pop_front();
                    check("wb_latency", 64'(cyc - a), 64'(e.lat));
                end
            end
        end else begin
            check("wb_idle_zero", 64'({bus.wb_we, bus.wb_rd, bus.wb_data, bus.exc_valid, bus.exc_cause}), 64'(0));
        end
    end

    // Data-memory responder: acks after the queued wait states, checks the request
    bt_t cur;
    int  n = 0;
    bit  busy = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy = 1'b0;
            bus.dmem_ack = 1'b0;
        end else if (bus.dmem_req) begin
            if (!busy) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_dmem_req: got addr=0x%0h required none", bus.dmem_addr);
                    cur.ws = 1000; cur.rdata = '0; cur.we = bus.dmem_we; cur.addr = bus.dmem_addr;
                    cur.wdata = bus.dmem_wdata; cur.be = bus.dmem_be; cur.req_cycles = 0;
                end else begin
                    cur = bus_q.pop_front();
                end
                busy = 1'b1;
                n = 0;
            end
            check("dmem_addr", 64'(bus.dmem_addr), 64'(cur.addr));
            check("dmem_we_be_wdata", 64'({bus.dmem_we, bus.dmem_be, bus.dmem_wdata}),
                  64'({cur.we, cur.be, cur.wdata}));
            n++;
            bus.dmem_ack   = ((n - 1) == cur.ws);
            bus.dmem_rdata = cur.rdata;
        end else begin
            if (busy) begin
                check("dmem_req_cycles", 64'(n), 64'(cur.req_cycles));
                busy = 1'b0;
            end
            bus.dmem_ack = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.is_store   = 1'b0;
        bus.mem_op     = 3'b000;
        bus.addr       = '0;
        bus.store_data = '0;
        bus.rd_in      = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.req_ready, bus.dmem_req, bus.wb_valid, bus.exc_valid}), 64'(4'b1000));
        reset_n = 1'b1;
        @(negedge clk);

        // LB sign-extended from byte 3, zero wait states
        exp_bus(0, 32'h80FF_FF7F, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1);
        exp_wb(1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 2'd0, 1);
        send(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5);
        bus.req_valid = 1'b0;
        drain();

        // LB positive byte 0
        exp_bus(0, 32'h80FF_FF7F, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1);
        exp_wb(1'b1, 5'd5, 32'h0000_007F, 1'b0, 2'd0, 1);
        send(1'b0, 3'b000, 32'h0000_1000, 32'h0, 5'd5);
        bus.req_valid = 1'b0;
        drain();

        // SH upper half, one wait state
        exp_bus(1, 32'h0, 1'b1, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 2);
        exp_wb(1'b0, 5'd6, 32'h0, 1'b0, 2'd0, 2);
        send(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd6);
        bus.req_valid = 1'b0;
        drain();

        // SW full word
        exp_bus(0, 32'h0, 1'b1, 32'h0000_2100, 32'hCAFE_F00D, 4'b1111, 1);
        exp_wb(1'b0, 5'd10, 32'h0, 1'b0, 2'd0, 1);
        send(1'b1, 3'b010, 32'h0000_2100, 32'hCAFE_F00D, 5'd10);
        bus.req_valid = 1'b0;
        drain();

        // Exceptions without a bus access
        exp_wb(1'b0, 5'd7, 32'h0, 1'b1, 2'd0, 0);
        send(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd7);
        bus.req_valid = 1'b0;
        drain();
        exp_wb(1'b0, 5'd7, 32'h0, 1'b1, 2'd1, 0);
        send(1'b1, 3'b010, 32'h0000_3001, 32'h0, 5'd7);
        bus.req_valid = 1'b0;
        drain();
        exp_wb(1'b0, 5'd1, 32'h0, 1'b1, 2'd3, 0);
        send(1'b0, 3'b011, 32'h0000_3000, 32'h0, 5'd1);
        bus.req_valid = 1'b0;
        drain();
        exp_wb(1'b0, 5'd2, 32'h0, 1'b1, 2'd3, 0);
        send(1'b1, 3'b100, 32'h0000_3000, 32'h0, 5'd2);
        bus.req_valid = 1'b0;
        drain();
        exp_wb(1'b0, 5'd14, 32'h0, 1'b1, 2'd0, 0);
        send(1'b0, 3'b101, 32'h0000_4001, 32'h0, 5'd14);
        bus.req_valid = 1'b0;
        drain();
        exp_wb(1'b0, 5'd15, 32'h0, 1'b1, 2'd1, 0);
        send(1'b1, 3'b001, 32'h0000_2003, 32'h0, 5'd15);
        bus.req_valid = 1'b0;
        drain();

        // LHU with ack withheld: bus timeout after T cycles
        exp_bus(99, 32'h0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, T);
        exp_wb(1'b0, 5'd8, 32'h0, 1'b1, 2'd2, T);
        send(1'b0, 3'b101, 32'h0000_4000, 32'h0, 5'd8);
        bus.req_valid = 1'b0;
        drain();

        // LHU with ack on the last permitted cycle completes normally
        exp_bus(T - 1, 32'h1234_F00D, 1'b0, 32'h0000_4000, 32'h0, 4'hF, T);
        exp_wb(1'b1, 5'd8, 32'h0000_F00D, 1'b0, 2'd0, T);
        send(1'b0, 3'b101, 32'h0000_4000, 32'h0, 5'd8);
        bus.req_valid = 1'b0;
        drain();

        // Reset asserted mid-BUSY drops the bus request at once
        exp_bus(3, 32'h0, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 4);
        send(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd11);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 64'({bus.dmem_req, bus.req_ready, bus.wb_valid}), 64'(3'b010));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.req_ready), 64'(1));

        // LBU after reset
        exp_bus(0, 32'h0000_9900, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 1);
        exp_wb(1'b1, 5'd12, 32'h0000_0099, 1'b0, 2'd0, 1);
        send(1'b0, 3'b100, 32'h0000_5001, 32'h0, 5'd12);
        bus.req_valid = 1'b0;
        drain();

        // Back-to-back with req_valid held high
        exp_wb(1'b0, 5'd9, 32'h0, 1'b1, 2'd0, 0);
        send(1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd9);
        exp_bus(0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1);
        exp_wb(1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 2'd0, 1);
        send(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd0);
        exp_bus(0, 32'h0, 1'b1, 32'h0000_7000, 32'h5555_5555, 4'b0010, 1);
        exp_wb(1'b0, 5'd3, 32'h0, 1'b0, 2'd0, 1);
        send(1'b1, 3'b000, 32'h0000_7001, 32'h0000_0055, 5'd3);
        exp_wb(1'b0, 5'd4, 32'h0, 1'b1, 2'd3, 0);
        send(1'b1, 3'b111, 32'h0000_7000, 32'h0, 5'd4);
        exp_bus(2, 32'h8001_0000, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 3);
        exp_wb(1'b1, 5'd13, 32'hFFFF_8001, 1'b0, 2'd0, 3);
        send(1'b0, 3'b001, 32'h0000_7002, 32'h0, 5'd13);
        bus.req_valid = 1'b0;
        drain();

        check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
        check("bus_queue_empty", 64'(bus_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting directly downstream of the execute ALU. It consumes the ALU-computed effective address plus the rs2 store operand, and performs one data-memory transaction per request over a req/ack bus. It handles byte/half/word alignment, byte enables and load sign/zero extension, then returns a single write-back result or exception.

## Interface
- XLEN, 32, data/address width (only 32 supported)
- TIMEOUT_CYCLES, 255, max cycles waiting for dmem_ack before bus-timeout exception (1..255)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present (held until accepted)
- req_ready  out  1  unit can accept; high only in IDLE
- is_store  in  1  1 = store, 0 = load
- mem_op  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- rd_in  in  5  destination register
- dmem_req  out  1  bus request, held until ack or timeout
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (writes); 4'b1111 on reads
- dmem_ack  in  1  transaction complete; rdata valid same cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  32  load result (0 for stores/exceptions)
- exc_valid  out  1  completion is an exception
- exc_cause  out  2  0 misaligned load, 1 misaligned store, 2 bus timeout, 3 illegal mem_op

## Operation
- States: IDLE, BUSY, RESP. Reset (async, reset_n low) -> IDLE; all outputs 0 except req_ready=1 once in IDLE.
- IDLE: req_ready=1. On req_valid, latch is_store, mem_op, addr, store_data, rd_in.
  - Illegal op (loads 011/110/111; stores any op other than 000/001/010) -> RESP, cause 3.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> RESP, cause 0 (load) / 1 (store).
  - Otherwise -> BUSY; timeout counter cleared.
- BUSY: dmem_req=1 and dmem_we/addr/wdata/be stable all cycles. On dmem_ack -> RESP, capture formatted result. If the counter reaches TIMEOUT_CYCLES without ack, drop req -> RESP, cause 2. Ack in the same cycle as expiry counts as success.
- RESP: wb_valid=1 for exactly one cycle, then IDLE.
- Store formatting: B wdata={4{sd[7:0]}}, be=4'b0001<<addr[1:0]; H wdata={2{sd[15:0]}}, be=4'b0011<<{addr[1],1'b0}; W wdata=sd, be=4'b1111.
- Load extraction: B/BU select byte addr[1:0] of rdata, then sign/zero extend; H/HU select half addr[1], then extend; W whole word.
- Completion fields:
  - Successful load: wb_we=(rd!=0), wb_data=result.
  - Store: wb_we=0, wb_data=0.
  - Exception: exc_valid=1, wb_we=0, wb_data=0, wb_rd=latched rd.
- Outputs wb_*/exc_* are 0 outside RESP.
- dmem_ack outside BUSY is ignored.

## Timing
- Accept at edge E0 (IDLE, req_valid). dmem_req is high from E0 until the edge sampling ack.
- Zero-wait-state bus (ack in the first BUSY cycle): wb_valid in the cycle after E1. Latency from accept = 2 cycles + wait states.
- Exceptions without a bus access: wb_valid in the cycle after E0 (1 cycle).
- Timeout: BUSY lasts TIMEOUT_CYCLES cycles, then RESP.
- Throughput: one request per (latency+1) cycles; req_ready=0 in BUSY/RESP.
- reset_n asserted mid-BUSY: dmem_req drops immediately (asynchronously), no wb_valid, state IDLE.

## Test plan
- LB addr=0x1003, rdata=0x80FF_FF7F, ack 1st cycle -> dmem_addr=0x1000, wb_data=0xFFFFFF80, wb_we=1, wb_valid 2 cycles after accept.
- SH addr=0x2002, store_data=0x1234_ABCD -> dmem_we=1, be=4'b1100, wdata=0xABCD_ABCD; completion with wb_we=0, exc_valid=0.
- LW addr=0x3001 -> no dmem_req, wb_valid next cycle, exc_valid=1, exc_cause=0; the same access as SW gives cause 1. mem_op=011 gives cause 3.
- LHU addr=0x4000, ack withheld, TIMEOUT_CYCLES=4 -> dmem_req high exactly 4 cycles, then exc_cause=2. Ack on the 4th cycle gives a normal completion instead.
- Load in BUSY with 3 wait states, reset_n pulsed low -> dmem_req=0 immediately, no wb_valid, req_ready=1 after release. A following LBU addr=0x5001, rdata=0x0000_9900 -> wb_data=0x99.
- Back-to-back requests with req_valid held high -> each accepted only when req_ready=1, exactly one wb_valid per request, rd=0 load gives wb_we=0.
